// File: rtl/ts_pkg.sv
// Shared definitions for the TS packet multiplexer slice.
//   TS_PKT_LEN   : bytes per transport-stream packet
//   TS_SYNC_BYTE : value every packet must start with
//   TS_NUM_CH    : tuner channel count
//   ts_state_e   : read-sequencer states
package ts_pkg;
  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_NUM_CH    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } ts_state_e;
endpackage

// File: rtl/ts_packet_mux_if.sv
// Bus bundle between the per-tuner FIFO stages, the mux and the output logic.
//   GOT_FULL_PACKET : per-channel "FIFO holds a whole packet"
//   DATA_IN         : per-channel FIFO q, channel i on [8i+7:8i]
//   RD_REQ          : per-channel FIFO read strobe (one-hot or zero)
//   DATA_OUT/D_VALID/P_SYNC/CH_OUT/SYNC_ERR : serialised TS stream
// master = the mux, slave = the surrounding FIFOs / output consumer.
interface ts_packet_mux_if
  import ts_pkg::*;
#(
  parameter int NUM_CH = TS_NUM_CH
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]   GOT_FULL_PACKET;
  logic [8*NUM_CH-1:0] DATA_IN;
  logic [NUM_CH-1:0]   RD_REQ;
  logic [7:0]          DATA_OUT;
  logic                D_VALID;
  logic                P_SYNC;
  logic [CH_W-1:0]     CH_OUT;
  logic                SYNC_ERR;

  modport master (
    input  GOT_FULL_PACKET, DATA_IN,
    output RD_REQ, DATA_OUT, D_VALID, P_SYNC, CH_OUT, SYNC_ERR
  );

  modport slave (
    output GOT_FULL_PACKET, DATA_IN,
    input  RD_REQ, DATA_OUT, D_VALID, P_SYNC, CH_OUT, SYNC_ERR
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req      : request vector
//   last_ptr : index granted last time; search starts at last_ptr+1 and wraps
//   gnt_vld  : any request present
//   gnt_idx  : chosen index (0 when gnt_vld=0)
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_ptr,
  output logic              gnt_vld,
  output logic [CH_W-1:0]   gnt_idx
);
  logic [CH_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last_ptr) + i) % NUM_CH);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
endmodule

// File: rtl/ts_packet_mux.sv
// Round-robin TS packet multiplexer: grants one channel holding a full packet,
// reads exactly PKT_LEN bytes from its FIFO and serialises them on DATA_OUT
// with D_VALID, P_SYNC (first byte) and CH_OUT (source channel).
//   SYS_CLK : clock, rising edge
//   RST     : asynchronous active-low reset
//   bus     : ts_packet_mux_if.master (FIFO side + output stream)
// Latency: a byte requested in cycle t is on the outputs in cycle t+2
// (1 cycle FIFO read latency + 1 output register).
// Optional build macro TS_MUX_SYNC_CHECK_EN: flags packets whose first byte is
// not 0x47 on SYNC_ERR and counts them in sync_err_cnt; otherwise SYNC_ERR=0.
module ts_packet_mux
  import ts_pkg::*;
#(
  parameter int NUM_CH     = TS_NUM_CH,
  parameter int PKT_LEN    = TS_PKT_LEN,
  parameter int GAP_CYCLES = 0
) (
  input logic             SYS_CLK,
  input logic             RST,
  ts_packet_mux_if.master bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_LEN - 1);
  localparam logic [3:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef struct packed {
    logic            first;
    logic [CH_W-1:0] ch;
  } s1_t;

  ts_state_e                     state;
  logic [CH_W-1:0]               cur_ch, last_ch, gnt_idx;
  logic                          gnt_vld;
  logic [CNT_W-1:0]              byte_cnt;
  logic [3:0]                    gap_cnt;
  logic                          rd_act;
  logic [NUM_CH-1:0]             rd_req;
  logic [NUM_CH-1:0][7:0]        din;
  logic [1:0]                    vld_pipe;  // [0]: FIFO q valid, [1]: D_VALID
  s1_t                           s1;
  logic [7:0]                    data_q;
  logic [CH_W-1:0]               ch_q;
  logic                          psync_q;

  assign din = bus.DATA_IN;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req      (bus.GOT_FULL_PACKET),
    .last_ptr (last_ch),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  // Read sequencer
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cur_ch   <= '0;
      last_ch  <= CH_W'(NUM_CH - 1);
      byte_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          cur_ch   <= gnt_idx;
          last_ch  <= gnt_idx;
          byte_cnt <= '0;
          state    <= READ;
        end
        READ: begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
            state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_act = (state == READ);

  always_comb begin
    rd_req = '0;
    if (rd_act) rd_req[cur_ch] = 1'b1;
  end

  // Pipeline runs independently of the sequencer so bursts drain on their own.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe <= '0;
      s1       <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      psync_q  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_act};
      s1.first <= rd_act && (byte_cnt == '0);
      s1.ch    <= cur_ch;
      psync_q  <= vld_pipe[0] && s1.first;
      if (vld_pipe[0]) begin
        data_q <= din[s1.ch];
        ch_q   <= s1.ch;
      end
    end
  end

  assign bus.RD_REQ   = rd_req;
  assign bus.DATA_OUT = data_q;
  assign bus.D_VALID  = vld_pipe[1];
  assign bus.P_SYNC   = psync_q;
  assign bus.CH_OUT   = ch_q;

`ifdef TS_MUX_SYNC_CHECK_EN
  // Evaluated on the byte entering the output register so the pulse lines
  // up with P_SYNC.
  logic        bad_sync;
  logic        sync_err_q;
  logic [15:0] sync_err_cnt;

  assign bad_sync = vld_pipe[0] && s1.first && (din[s1.ch] != TS_SYNC_BYTE);

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      sync_err_q   <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      sync_err_q <= bad_sync;
      if (bad_sync && (sync_err_cnt != 16'hFFFF)) sync_err_cnt <= sync_err_cnt + 1'b1;
    end
  end

  assign bus.SYNC_ERR = sync_err_q;
`else
  assign bus.SYNC_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_ts_packet_mux.sv
// Bench for ts_packet_mux: per-channel FIFO responders, a schedule-level model
// (grant -> PKT_LEN reads -> outputs two cycles later) checked every cycle,
// directed phases with literal expectations, and a second instance with
// GAP_CYCLES=3 whose read spacing is monitored.
module tb_ts_packet_mux;
  import ts_pkg::*;

  localparam int NCH = 4;
  localparam int PL  = 188;

  logic SYS_CLK = 1'b0;
  logic RST;
  always #5 SYS_CLK = ~SYS_CLK;

  ts_packet_mux_if #(.NUM_CH(NCH)) bus   ();
  ts_packet_mux_if #(.NUM_CH(NCH)) bus_g ();

  ts_packet_mux #(.NUM_CH(NCH), .PKT_LEN(PL), .GAP_CYCLES(0)) u_dut (
    .SYS_CLK (SYS_CLK), .RST (RST), .bus (bus));

  ts_packet_mux #(.NUM_CH(NCH), .PKT_LEN(PL), .GAP_CYCLES(3)) u_dut_g (
    .SYS_CLK (SYS_CLK), .RST (RST), .bus (bus_g));

  assign bus_g.GOT_FULL_PACKET = 4'b0001;
  assign bus_g.DATA_IN         = '0;

  int n_vec = 0, n_err = 0, cyc = 0;
  int bad_n [NCH] = '{-1, -1, -1, -1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Byte k of channel c's stream: packet n = k/PL, offset j = k%PL.
  function automatic logic [7:0] fifo_byte(input int c, input int k);
    int j, n;
    j = k % PL;
    n = k / PL;
    if (j == 0) return (bad_n[c] == n) ? 8'h46 : 8'h47;
    return 8'(j + 16 * c + 5 * n);
  endfunction

  function automatic int realign(input int k);
    return ((k + PL - 1) / PL) * PL;
  endfunction

  // FIFO responders: 1-cycle read latency; realign to a packet boundary on reset.
  int fpos [NCH] = '{0, 0, 0, 0};
  always @(posedge SYS_CLK) begin
    for (int c = 0; c < NCH; c++) begin
      if (!RST) fpos[c] = realign(fpos[c]);
      else if (bus.RD_REQ[c]) begin
        bus.DATA_IN[8*c +: 8] <= fifo_byte(c, fpos[c]);
        fpos[c] = fpos[c] + 1;
      end
    end
  end

  // ---------------- model + per-cycle compare ----------------
  typedef struct packed {
    logic       vld;
    logic       first;
    logic [1:0] ch;
    logic [7:0] b;
  } rd_t;

  rd_t        h0 = '0, h1 = '0;
  int         m_last = NCH - 1, m_ch = 0, rd_start = 0, rd_end = -1, next_arb = 0;
  int         m_pos [NCH] = '{0, 0, 0, 0};
  logic [7:0] e_data = '0;
  logic [1:0] e_ch = '0;

  // logs of the observed stream for the directed checks
  logic [7:0] out_q [$];
  int         ps_ch [$], ps_cyc [$], rq_cyc [$];
  int         dv_rise = 0, serr_n = 0;
  logic       prev_dv = 1'b0;
  logic [3:0] prev_req = '0;

  always @(negedge SYS_CLK) begin
    rd_t        cur;
    logic [3:0] e_req;
    logic       e_ps, e_se;
    int         g;
    cyc++;
    if (!RST) begin
      chk("rst_rd_req", bus.RD_REQ, 0);
      chk("rst_d_valid", bus.D_VALID, 0);
      chk("rst_p_sync", bus.P_SYNC, 0);
      chk("rst_data_out", bus.DATA_OUT, 0);
      chk("rst_ch_out", bus.CH_OUT, 0);
      chk("rst_sync_err", bus.SYNC_ERR, 0);
      h0 = '0; h1 = '0; e_data = '0; e_ch = '0;
      m_last = NCH - 1; rd_start = 0; rd_end = -1; next_arb = cyc + 1;
      for (int c = 0; c < NCH; c++) m_pos[c] = realign(m_pos[c]);
    end else begin
      if (h1.vld) begin e_data = h1.b; e_ch = h1.ch; end
      e_ps = h1.vld && h1.first;
`ifdef TS_MUX_SYNC_CHECK_EN
      e_se = e_ps && (e_data != TS_SYNC_BYTE);
`else
      e_se = 1'b0;
`endif
      chk("d_valid", bus.D_VALID, h1.vld);
      chk("p_sync", bus.P_SYNC, e_ps);
      chk("data_out", bus.DATA_OUT, e_data);
      chk("ch_out", bus.CH_OUT, e_ch);
      chk("sync_err", bus.SYNC_ERR, e_se);

      cur = '0; e_req = '0;
      if (cyc >= rd_start && cyc <= rd_end) begin
        cur.vld = 1'b1; cur.first = (cyc == rd_start); cur.ch = 2'(m_ch);
        cur.b = fifo_byte(m_ch, m_pos[m_ch]);
        m_pos[m_ch]++;
        e_req[m_ch] = 1'b1;
      end
      chk("rd_req", bus.RD_REQ, e_req);

      if (cyc >= next_arb) begin
        g = -1;
        for (int o = 1; o <= NCH; o++)
          if (g < 0 && bus.GOT_FULL_PACKET[(m_last + o) % NCH]) g = (m_last + o) % NCH;
        if (g >= 0) begin
          m_ch = g; m_last = g;
          rd_start = cyc + 1; rd_end = cyc + PL; next_arb = cyc + PL + 1;
        end
      end
      h1 = h0; h0 = cur;
    end

    if (bus.D_VALID) out_q.push_back(bus.DATA_OUT);
    if (bus.P_SYNC) begin ps_ch.push_back(int'(bus.CH_OUT)); ps_cyc.push_back(cyc); end
    if (bus.RD_REQ != 0 && prev_req == 0) rq_cyc.push_back(cyc);
    if (bus.D_VALID && !prev_dv) dv_rise++;
    if (bus.SYNC_ERR) serr_n++;
    prev_dv = bus.D_VALID; prev_req = bus.RD_REQ;
  end

  // GAP_CYCLES=3 instance: idle run between read bursts must be GAP+1 = 4.
  int zr = 0, gap_chk = 0;
  bit seen = 0;
  always @(negedge SYS_CLK) begin
    if (!RST) begin seen = 0; zr = 0; end
    else if (bus_g.RD_REQ != 0) begin
      chk("gap_rd_req", bus_g.RD_REQ, 4'b0001);
      if (seen && zr > 0) begin chk("gap_idle_run", zr, 4); gap_chk++; end
      zr = 0; seen = 1;
    end else zr++;
  end

  // ---------------- directed phases ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge SYS_CLK); #2; end
  endtask

  task automatic wait_req(input int lim, input string nm);
    int k = 0;
    while (bus.RD_REQ == '0 && k < lim) begin step(1); k++; end
    chk({nm, "_in_time"}, k < lim, 1);
  endtask

  task automatic clear_logs();
    out_q.delete(); ps_ch.delete(); ps_cyc.delete(); rq_cyc.delete();
    dv_rise = 0; serr_n = 0;
  endtask

  function automatic int q_at(input int i);
    return (out_q.size() > i) ? int'(out_q[i]) : -1;
  endfunction

  function automatic int ps_at(input int i);
    return (ps_ch.size() > i) ? ps_ch[i] : -1;
  endfunction

  initial begin
    int k;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    RST = 1'b0;
    bus.GOT_FULL_PACKET = '0;
    bus.DATA_IN = '0;
    step(3);
    chk("lit_rst_d_valid", bus.D_VALID, 0);
    chk("lit_rst_rd_req", bus.RD_REQ, 0);

    // A: single channel 2
    clear_logs();
    RST = 1'b1; bus.GOT_FULL_PACKET = 4'b0100;
    wait_req(5, "A_grant");
    chk("A_rd_req", bus.RD_REQ, 4'b0100);
    bus.GOT_FULL_PACKET = '0;
    step(200);
    chk("A_bursts", ps_ch.size(), 1);
    chk("A_ch", ps_at(0), 2);
    chk("A_latency", (ps_cyc.size() > 0 && rq_cyc.size() > 0) ? ps_cyc[0] - rq_cyc[0] : -1, 2);
    chk("A_nbytes", out_q.size(), PL);
    chk("A_byte0", q_at(0), 8'h47);
    chk("A_byte1", q_at(1), 8'h21);
    chk("A_byte187", q_at(187), 8'hDB);

    // B: all four full, pointer reset -> 0,1,2,3,0,1,2,3
    RST = 1'b0; step(2);
    clear_logs();
    RST = 1'b1; bus.GOT_FULL_PACKET = 4'b1111;
    k = 0;
    while (rq_cyc.size() < 8 && k < 2000) begin step(1); k++; end
    chk("B_in_time", k < 2000, 1);
    bus.GOT_FULL_PACKET = '0;
    step(200);
    for (int i = 0; i < 8; i++) chk($sformatf("B_order%0d", i), ps_at(i), exp_order[i]);
    chk("B_bursts_separated", dv_rise, 8);
    chk("B_nbytes", out_q.size(), 8 * PL);

    // C: channel 1 drops GOT_FULL_PACKET at read cycle 50
    clear_logs();
    bus.GOT_FULL_PACKET = 4'b0010;
    wait_req(5, "C_grant");
    step(49);
    bus.GOT_FULL_PACKET = '0;
    step(300);
    chk("C_bursts", ps_ch.size(), 1);
    chk("C_ch", ps_at(0), 1);
    chk("C_nbytes", out_q.size(), PL);
    clear_logs();
    bus.GOT_FULL_PACKET = 4'b0010;
    wait_req(5, "C_regrant");
    chk("C_regrant_req", bus.RD_REQ, 4'b0010);
    bus.GOT_FULL_PACKET = '0;
    step(200);
    chk("C_re_nbytes", out_q.size(), PL);

    // D: reset mid-packet on channel 0, then channels 0 and 3 full
    bus.GOT_FULL_PACKET = 4'b0001;
    wait_req(5, "D_grant");
    step(99);
    RST = 1'b0;
    #1;
    chk("D_rst_rd_req", bus.RD_REQ, 0);
    chk("D_rst_d_valid", bus.D_VALID, 0);
    chk("D_rst_data", bus.DATA_OUT, 0);
    chk("D_rst_ch", bus.CH_OUT, 0);
    step(3);
    clear_logs();
    bus.GOT_FULL_PACKET = 4'b1001; RST = 1'b1;
    wait_req(5, "D_grant2");
    chk("D_grant_ch0", bus.RD_REQ, 4'b0001);
    bus.GOT_FULL_PACKET = '0;
    step(200);
    chk("D_bursts", ps_ch.size(), 1);
    chk("D_ch", ps_at(0), 0);
    chk("D_byte0", q_at(0), 8'h47);
    chk("D_byte1", q_at(1), 8'h10);
    chk("D_nbytes", out_q.size(), PL);

    // E: channel 3's third packet starts with 0x46
    clear_logs();
    bad_n[3] = 2;
    bus.GOT_FULL_PACKET = 4'b1000;
    wait_req(5, "E_grant");
    bus.GOT_FULL_PACKET = '0;
    step(200);
    chk("E_ch", ps_at(0), 3);
    chk("E_byte0", q_at(0), 8'h46);
    chk("E_nbytes", out_q.size(), PL);
`ifdef TS_MUX_SYNC_CHECK_EN
    chk("E_sync_err_pulses", serr_n, 1);
    chk("E_sync_err_cnt", u_dut.sync_err_cnt, 1);
`else
    chk("E_sync_err_pulses", serr_n, 0);
`endif
    chk("gap_runs_seen", gap_chk >= 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
